// File: rtl/rescale_pkg.sv
// Shared types and helpers for the rescale_stream datapath.
// Optional rounding is selected with the RESCALE_ROUND_EN macro (see rescale_lane).
package rescale_pkg;

    localparam int NUM_W   = 33;
    localparam int IMG_W   = 16;
    localparam int CH_N    = 4;
    localparam int CNT_W   = 16;
    localparam int SHIFT_W = 8;

    // Output of one lane's saturate stage; data width follows IMG_W.
    typedef struct packed {
        logic [IMG_W-1:0] data;
        logic             sat_flag;
    } lane_res_t;

    function automatic logic signed [63:0] img_max(input int img_w);
        return (64'sd1 <<< (img_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] img_min(input int img_w);
        return -(64'sd1 <<< (img_w - 1));
    endfunction

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh,
                                                       input int                 lim);
        logic [SHIFT_W-1:0] lim_v;
        lim_v = SHIFT_W'(lim);
        return (sh > lim_v) ? lim_v : sh;
    endfunction

endpackage

// File: rtl/rescale_stream_if.sv
// Upstream/downstream beat bus of rescale_stream. Both sides use valid/ready:
// a beat moves on a cycle where valid and ready are both high; ready never depends on valid.
interface rescale_stream_if #(
    parameter int NUM_WIDTH = 33,
    parameter int IMG_WIDTH = 16,
    parameter int CHANNELS  = 4
);
    logic [7:0]                    up_shift;
    logic [CHANNELS*NUM_WIDTH-1:0] up_data;
    logic                          up_valid;
    logic                          up_ready;
    logic [CHANNELS*IMG_WIDTH-1:0] dn_data;
    logic                          dn_valid;
    logic                          dn_ready;

    modport slave (
        input  up_shift, up_data, up_valid, dn_ready,
        output up_ready, dn_data, dn_valid
    );

    modport master (
        output up_shift, up_data, up_valid, dn_ready,
        input  up_ready, dn_data, dn_valid
    );
endinterface

// File: rtl/rescale_lane.sv
// One lane of the rescaler: S1 extend/round, S2 arithmetic shift, S3 saturate.
// RESCALE_ROUND_EN adds 2^(shift-1) in S1 (round half up); otherwise results truncate.
module rescale_lane
    import rescale_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_W,
    parameter int IMG_WIDTH = IMG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv_i,
    input  logic [NUM_WIDTH-1:0] num_i,
    input  logic [SHIFT_W-1:0]   shift_i,
    output lane_res_t            res_o
);

    localparam int EW = NUM_WIDTH + 1;
    localparam logic signed [EW-1:0] SAT_HI = EW'(img_max(IMG_WIDTH));
    localparam logic signed [EW-1:0] SAT_LO = EW'(img_min(IMG_WIDTH));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] s1_d, s1_q;
    logic signed [EW-1:0] s2_d, s2_q;
    logic [SHIFT_W-1:0]   sh1_q;
    lane_res_t            s3_d, s3_q;

    // One extra bit of headroom so the round add can never overflow.
    always_comb begin
        ext  = {num_i[NUM_WIDTH-1], num_i};
        s1_d = ext;
`ifdef RESCALE_ROUND_EN
        if (shift_i != '0) begin
            s1_d = ext + (EW'(1) << (shift_i - 1'b1));
        end
`endif
    end

    assign s2_d = s1_q >>> sh1_q;

    always_comb begin
        s3_d.data     = s2_q[IMG_W-1:0];
        s3_d.sat_flag = 1'b0;
        if (s2_q > SAT_HI) begin
            s3_d.data     = IMG_W'(img_max(IMG_WIDTH));
            s3_d.sat_flag = 1'b1;
        end else if (s2_q < SAT_LO) begin
            s3_d.data     = IMG_W'(img_min(IMG_WIDTH));
            s3_d.sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            sh1_q <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
        end else if (adv_i) begin
            s1_q  <= s1_d;
            sh1_q <= shift_i;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
        end
    end

    assign res_o = s3_q;

endmodule

// File: rtl/rescale_stream.sv
// Multi-lane accumulator-to-image rescaler with a 3-stage stalling pipeline and saturation counter.
// Rounding is built only when RESCALE_ROUND_EN is defined.
module rescale_stream
    import rescale_pkg::*;
#(
    parameter int NUM_WIDTH = NUM_W,
    parameter int IMG_WIDTH = IMG_W,
    parameter int CHANNELS  = CH_N,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    rescale_stream_if.slave      bus,
    input  logic                 sat_clear,
    output logic [CNT_WIDTH-1:0] sat_count
);

    localparam int INC_W = $clog2(CHANNELS + 1);

    logic                 adv;
    logic [SHIFT_W-1:0]   shift_eff;
    logic                 v1_q, v2_q, v3_q;
    lane_res_t            res [CHANNELS];
    logic [INC_W-1:0]     sat_inc;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

    // A single enable moves every stage at once; the output slot frees when drained or empty.
    assign adv          = ~v3_q | bus.dn_ready;
    assign bus.up_ready = adv;
    assign bus.dn_valid = v3_q;
    assign sat_count    = cnt_q;
    assign shift_eff    = clamp_shift(bus.up_shift, NUM_WIDTH - IMG_WIDTH);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        rescale_lane #(
            .NUM_WIDTH(NUM_WIDTH),
            .IMG_WIDTH(IMG_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .num_i  (bus.up_data[g*NUM_WIDTH +: NUM_WIDTH]),
            .shift_i(shift_eff),
            .res_o  (res[g])
        );
        assign bus.dn_data[g*IMG_WIDTH +: IMG_WIDTH] = IMG_WIDTH'(res[g].data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= bus.up_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
    end

    always_comb begin
        sat_inc = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sat_inc = sat_inc + INC_W'(res[i].sat_flag);
        end
    end

    // Clear wins over a coincident transfer; the count sticks at all-ones.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_WIDTH + 1)'(sat_inc);
        cnt_d   = cnt_q;
        if (sat_clear) begin
            cnt_d = '0;
        end else if (v3_q && bus.dn_ready) begin
            cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rescale_stream.sv
// Self-checking bench for rescale_stream: directed cases plus randomized traffic
// scored against an arithmetic reference model.
module tb_rescale_stream;

    localparam int NW = 33;
    localparam int IW = 16;
    localparam int CH = 4;
    localparam int CW = 16;
    localparam int DW = NW * CH;
    localparam int OW = IW * CH;
    localparam longint CNT_MAX = (longint'(1) << CW) - 1;

    logic          clk;
    logic          rst;
    logic          sat_clear;
    logic [CW-1:0] sat_count;

    rescale_stream_if #(.NUM_WIDTH(NW), .IMG_WIDTH(IW), .CHANNELS(CH)) bus ();

    rescale_stream #(
        .NUM_WIDTH(NW),
        .IMG_WIDTH(IW),
        .CHANNELS (CH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sat_clear(sat_clear),
        .sat_count(sat_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic [OW-1:0] exp_q[$];
    int          exp_sat_q[$];
    longint      model_cnt = 0;
    logic [OW-1:0] m_o;
    int          m_ns;
    int          m_inc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: plain signed arithmetic on each lane
    function automatic void model_beat(input logic [DW-1:0] d, input logic [7:0] sh,
                                       output logic [OW-1:0] o, output int ns);
        logic signed [NW-1:0] w;
        longint v, r, hi, lo;
        int s;
        o  = '0;
        ns = 0;
        hi = (longint'(1) << (IW - 1)) - 1;
        lo = -(longint'(1) << (IW - 1));
        s  = (int'(sh) > NW - IW) ? NW - IW : int'(sh);
        for (int i = 0; i < CH; i++) begin
            w = d[i*NW +: NW];
            v = w;
`ifdef RESCALE_ROUND_EN
            if (s > 0) v = v + (longint'(1) << (s - 1));
`endif
            r = v >>> s;
            if (r > hi) begin
                o[i*IW +: IW] = IW'(hi);
                ns++;
            end else if (r < lo) begin
                o[i*IW +: IW] = IW'(lo);
                ns++;
            end else begin
                o[i*IW +: IW] = r[IW-1:0];
            end
        end
    endfunction

    function automatic logic [DW-1:0] pack4(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                            input logic [NW-1:0] c, input logic [NW-1:0] d);
        return {d, c, b, a};
    endfunction

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_sat_q.delete();
            model_cnt = 0;
        end else begin
            check("sat_count", sat_count, model_cnt);
            check("up_ready", bus.up_ready, !bus.dn_valid || bus.dn_ready);
            if (bus.up_valid && bus.up_ready) begin
                model_beat(bus.up_data, bus.up_shift, m_o, m_ns);
                exp_q.push_back(m_o);
                exp_sat_q.push_back(m_ns);
            end
            m_inc = 0;
            if (bus.dn_valid && bus.dn_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("dn_extra", 1, 0);
                end else begin
                    check("dn_data", bus.dn_data, exp_q.pop_front());
                    m_inc = exp_sat_q.pop_front();
                end
            end
            if (sat_clear) begin
                model_cnt = 0;
            end else begin
                model_cnt = model_cnt + m_inc;
                if (model_cnt > CNT_MAX) model_cnt = CNT_MAX;
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_single(input logic [DW-1:0] d, input logic [7:0] sh, output int lat);
        bus.up_data  = d;
        bus.up_shift = sh;
        bus.up_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        lat = 1;
        while (!bus.dn_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        bus.up_valid = 1'b0;
        bus.dn_ready = 1'b1;
        sat_clear    = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || bus.dn_valid) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    logic [DW-1:0] d;
    logic [NW-1:0] w;
    int            lat;
    int            k;
    int            c;
    logic          acc;

    initial begin
        rst          = 1'b1;
        sat_clear    = 1'b0;
        bus.up_valid = 1'b0;
        bus.up_data  = '0;
        bus.up_shift = '0;
        bus.dn_ready = 1'b1;
        idle(3);
        check("rst_dn_valid", bus.dn_valid, 0);
        check("rst_dn_data", bus.dn_data, 0);
        check("rst_sat_count", sat_count, 0);
        rst = 1'b0;
        idle(2);
        check("up_ready_after_rst", bus.up_ready, 1);

        // truncate path
        w = 33'h0_0001_2345;
        send_single(pack4(w, w, w, w), 8'd4, lat);
        check("trunc_latency", lat, 3);
        check("trunc_data", bus.dn_data, {4{16'h1234}});
        idle(2);
        check("trunc_sat", sat_count, 0);

        // rounding behaviour
        send_single(pack4(33'h0_0000_0018, 33'h1_FFFF_FFE8, 33'h0, 33'h0_0000_0100), 8'd4, lat);
        check("round_latency", lat, 3);
`ifdef RESCALE_ROUND_EN
        check("round_pos", bus.dn_data[15:0], 16'h0002);
        check("round_neg", bus.dn_data[31:16], 16'hFFFF);
`else
        check("round_pos", bus.dn_data[15:0], 16'h0001);
        check("round_neg", bus.dn_data[31:16], 16'hFFFE);
`endif
        check("round_exact", bus.dn_data[63:48], 16'h0010);
        idle(2);

        // saturation and shift clamp
        send_single(pack4(33'h0_0010_0000, 33'h0, 33'h0, 33'h0), 8'd4, lat);
        check("sat_hi", bus.dn_data[15:0], 16'h7FFF);
        idle(1);
        send_single(pack4(33'h0, 33'h1_FFF0_0000, 33'h0, 33'h0), 8'd0, lat);
        check("sat_lo", bus.dn_data[31:16], 16'h8000);
        idle(1);
        send_single(pack4(33'h0, 33'h0, 33'h0_0000_0100, 33'h0), 8'd200, lat);
        check("clamp_shift", bus.dn_data[47:32], 16'h0000);
        idle(2);
        check("sat_count_plus2", sat_count, 2);

        // randomized traffic with random backpressure and clears
        for (int i = 0; i < 400; i++) begin
            bus.up_valid = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < CH; l++) begin
                case ($urandom_range(0, 2))
                    0: w = {1'($urandom_range(0, 1)), 32'($urandom)};
                    1: w = NW'(int'($urandom_range(0, 200000)) - 100000);
                    default: w = NW'(int'($urandom_range(0, 4000000)) - 2000000);
                endcase
                d[l*NW +: NW] = w;
            end
            bus.up_data  = d;
            bus.up_shift = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 20));
            bus.dn_ready = ($urandom_range(0, 3) != 0);
            sat_clear    = ($urandom_range(0, 31) == 0);
            idle(1);
        end
        drain();

        // 20 beats: steady, then a 5-cycle stall, then toggling ready
        n_out = 0;
        k     = 0;
        c     = 0;
        while ((k < 20 || exp_q.size() != 0) && c < 200) begin
            bus.dn_ready = (c >= 6 && c < 11) ? 1'b0 : ((c >= 11) ? c[0] : 1'b1);
            bus.up_valid = (k < 20);
            for (int l = 0; l < CH; l++) d[l*NW +: NW] = NW'(k * 16 + l);
            bus.up_data  = d;
            bus.up_shift = 8'd0;
            @(negedge clk);
            acc = bus.up_valid && bus.up_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            c++;
        end
        check("bp_beats_out", n_out, 20);
        drain();

        // fill the counter to all-ones
        bus.up_data  = pack4(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF);
        bus.up_shift = 8'd0;
        bus.up_valid = 1'b1;
        bus.dn_ready = 1'b1;
        idle(16400);
        drain();
        check("cnt_full", sat_count, 16'hFFFF);
        send_single(pack4(33'h0_7FFF_FFFF, 33'h1_0000_0000, 33'h0, 33'h0), 8'd0, lat);
        idle(2);
        check("cnt_sticky", sat_count, 16'hFFFF);

        // clear coincident with a saturating transfer
        bus.dn_ready = 1'b0;
        bus.up_data  = pack4(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 33'h0, 33'h0);
        bus.up_shift = 8'd0;
        bus.up_valid = 1'b1;
        idle(1);
        bus.up_valid = 1'b0;
        c = 0;
        while (!bus.dn_valid && c < 10) begin
            idle(1);
            c++;
        end
        check("clr_dn_valid", bus.dn_valid, 1);
        sat_clear    = 1'b1;
        bus.dn_ready = 1'b1;
        idle(1);
        sat_clear = 1'b0;
        check("clr_priority", sat_count, 0);
        idle(2);

        // reset with three beats in flight
        send_single(pack4(33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF, 33'h0_7FFF_FFFF),
                    8'd0, lat);
        idle(2);
        check("pre_rst_cnt", sat_count, 4);
        bus.up_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.up_data = pack4(NW'(i + 1), NW'(i + 2), NW'(i + 3), NW'(i + 4));
            idle(1);
        end
        bus.up_valid = 1'b0;
        check("inflight_dn_valid", bus.dn_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_dn_valid", bus.dn_valid, 0);
        check("rst_async_cnt", sat_count, 0);
        check("rst_async_data", bus.dn_data, 0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", bus.dn_valid, 0);
        w = 33'h0_0000_5670;
        send_single(pack4(w, w, w, w), 8'd4, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_data", bus.dn_data, {4{16'h0567}});
        idle(6);
        check("post_rst_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
